// File: rtl/register_file_operand_stage.sv
// Operand stage: instruction register, 4 x WORD_SIZE register file, registered ALU operands
// with write-read bypass, and a registered zero flag for branch microcode.

module rf_reg_cell #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [WORD_SIZE-1:0] d_i,
    output logic [WORD_SIZE-1:0] q_o
);
    logic [WORD_SIZE-1:0] data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else if (we_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;
endmodule

module register_file_operand_stage #(
    parameter int WORD_SIZE = 16,
    parameter int REG_COUNT = 4,
    parameter int UOP_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ir_load,
    input  logic [WORD_SIZE-1:0] instruction_in,
    input  logic [UOP_WIDTH-1:0] uop_control,
    input  logic [WORD_SIZE-1:0] alu_result,
    input  logic [WORD_SIZE-1:0] mem_data,
    output logic [WORD_SIZE-1:0] operand_a,
    output logic [WORD_SIZE-1:0] operand_b,
    output logic [WORD_SIZE-1:0] store_data,
    output logic [7:0]           ir_opcode,
    output logic                 zero_flag
);
    localparam int IDX_W = 2;

    typedef struct packed {
        logic wb_sel_mem;
        logic wb_enable;
        logic b_sel_imm;
        logic latch_b;
        logic latch_a;
    } uop_t;

    uop_t uop;
    assign uop = uop_t'(uop_control[4:0]);

    // Upper control bits are reserved for other stages.
    logic unused_uop;
    assign unused_uop = ^uop_control[UOP_WIDTH-1:5];

    logic [WORD_SIZE-1:0] ir_q, ir_d;
    logic [WORD_SIZE-1:0] opa_q, opa_d;
    logic [WORD_SIZE-1:0] opb_q, opb_d;
    logic                 zero_q, zero_d;

    logic [REG_COUNT-1:0][WORD_SIZE-1:0] rf_q;
    logic [REG_COUNT-1:0]                rf_we;

    logic [IDX_W-1:0]     rd, ra, rb;
    logic [WORD_SIZE-1:0] imm;
    logic [WORD_SIZE-1:0] wb_data;

    // Fields always come from the currently held IR, so a same-cycle load affects the next cycle only.
    assign rd      = ir_q[7:6];
    assign ra      = ir_q[5:4];
    assign rb      = ir_q[3:2];
    assign imm     = {{(WORD_SIZE-8){1'b0}}, ir_q[7:0]};
    assign wb_data = uop.wb_sel_mem ? mem_data : alu_result;

    genvar g;
    generate
        for (g = 0; g < REG_COUNT; g++) begin : g_rf
            assign rf_we[g] = uop.wb_enable && (rd == IDX_W'(g));
            rf_reg_cell #(.WORD_SIZE(WORD_SIZE)) u_cell (
                .clock (clock),
                .reset (reset),
                .we_i  (rf_we[g]),
                .d_i   (wb_data),
                .q_o   (rf_q[g])
            );
        end
    endgenerate

    always_comb begin
        ir_d   = ir_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        zero_d = zero_q;
        if (ir_load) begin
            ir_d = instruction_in;
        end
        // Bypass the value being written this cycle so operands never see the stale entry.
        if (uop.latch_a) begin
            opa_d = (uop.wb_enable && rd == ra) ? wb_data : rf_q[ra];
        end
        if (uop.latch_b) begin
            if (uop.b_sel_imm) begin
                opb_d = imm;
            end else begin
                opb_d = (uop.wb_enable && rd == rb) ? wb_data : rf_q[rb];
            end
        end
        if (uop.wb_enable) begin
            zero_d = (wb_data == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q   <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            ir_q   <= ir_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            zero_q <= zero_d;
        end
    end

    assign operand_a  = opa_q;
    assign operand_b  = opb_q;
    assign store_data = rf_q[rd];
    assign ir_opcode  = ir_q[WORD_SIZE-1 -: 8];
    assign zero_flag  = zero_q;
endmodule

// File: tb/tb_register_file_operand_stage.sv
// Directed bench for register_file_operand_stage: hand-computed expectations checked with
// immediate assertions after each clock edge.

module tb_register_file_operand_stage;
    logic        clock = 1'b0;
    logic        reset;
    logic        ir_load;
    logic [15:0] instruction_in;
    logic [7:0]  uop_control;
    logic [15:0] alu_result;
    logic [15:0] mem_data;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [15:0] store_data;
    logic [7:0]  ir_opcode;
    logic        zero_flag;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [7:0] U_LA  = 8'h01;
    localparam logic [7:0] U_LB  = 8'h02;
    localparam logic [7:0] U_IMM = 8'h04;
    localparam logic [7:0] U_WB  = 8'h08;
    localparam logic [7:0] U_MEM = 8'h10;

    register_file_operand_stage dut (
        .clock          (clock),
        .reset          (reset),
        .ir_load        (ir_load),
        .instruction_in (instruction_in),
        .uop_control    (uop_control),
        .alu_result     (alu_result),
        .mem_data       (mem_data),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .store_data     (store_data),
        .ir_opcode      (ir_opcode),
        .zero_flag      (zero_flag)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ir_load = 1'b0; instruction_in = '0; uop_control = '0;
        alu_result = '0; mem_data = '0;

        // Reset for two cycles
        step(); step();
        reset = 1'b0;
        check("reset_opa",  operand_a, 16'h0000);
        check("reset_opb",  operand_b, 16'h0000);
        check("reset_zero", {15'd0, zero_flag}, 16'h0000);
        check("reset_opc",  {8'd0, ir_opcode}, 16'h0000);

        // Load IR = 12E4 (rd=3, ra=2, rb=1)
        ir_load = 1'b1; instruction_in = 16'h12E4;
        step();
        ir_load = 1'b0;
        check("load_opc", {8'd0, ir_opcode}, 16'h0012);

        // Writeback BEEF to reg3; store_data has no bypass before the edge
        uop_control = U_WB; alu_result = 16'hBEEF;
        #1;
        check("store_no_bypass", store_data, 16'h0000);
        step();
        uop_control = '0;
        check("wb_store",  store_data, 16'hBEEF);
        check("wb_zero",   {15'd0, zero_flag}, 16'h0000);

        // Latch operands under IR 12E4: ra=2 and rb=1 are both still zero
        uop_control = U_LA | U_LB;
        step();
        check("ra2_opa", operand_a, 16'h0000);
        check("rb1_opb", operand_b, 16'h0000);

        // Load IR = 0030 (ra=3), then latch_a
        ir_load = 1'b1; instruction_in = 16'h0030; uop_control = '0;
        step();
        ir_load = 1'b0; uop_control = U_LA;
        step();
        check("latch_a_ra3", operand_a, 16'hBEEF);

        // Load 00A5 together with an immediate latch: old imm 0x30 is used
        ir_load = 1'b1; instruction_in = 16'h00A5; uop_control = U_LB | U_IMM;
        step();
        ir_load = 1'b0;
        check("old_field_imm", operand_b, 16'h0030);
        step();
        uop_control = '0;
        check("imm_select", operand_b, 16'h00A5);

        // Bypass: IR 0050 (rd=1, ra=1), write and latch together
        ir_load = 1'b1; instruction_in = 16'h0050;
        step();
        ir_load = 1'b0; uop_control = U_WB | U_LA; alu_result = 16'h0007;
        step();
        uop_control = '0;
        check("bypass_opa",   operand_a, 16'h0007);
        check("bypass_store", store_data, 16'h0007);

        // Reserved bits only: nothing changes
        uop_control = 8'hE0; alu_result = 16'h1111; mem_data = 16'h2222;
        instruction_in = 16'hFFFF;
        step();
        uop_control = '0;
        check("rsvd_opa",   operand_a, 16'h0007);
        check("rsvd_opb",   operand_b, 16'h00A5);
        check("rsvd_store", store_data, 16'h0007);
        check("rsvd_opc",   {8'd0, ir_opcode}, 16'h0000);

        // Memory writeback of zero sets zero_flag
        uop_control = U_WB | U_MEM; mem_data = 16'h0000; alu_result = 16'hFFFF;
        step();
        uop_control = '0;
        check("mem_wb_store", store_data, 16'h0000);
        check("mem_wb_zero",  {15'd0, zero_flag}, 16'h0001);
        step();
        check("zero_hold", {15'd0, zero_flag}, 16'h0001);

        // Nonzero memory writeback clears it
        uop_control = U_WB | U_MEM; mem_data = 16'h1234; alu_result = 16'h0000;
        step();
        uop_control = '0;
        check("mem_wb2_store", store_data, 16'h1234);
        check("mem_wb2_zero",  {15'd0, zero_flag}, 16'h0000);

        // Latch_b from register with bypass: IR 0054 (rd=1, rb=1)
        ir_load = 1'b1; instruction_in = 16'h0054;
        step();
        ir_load = 1'b0; uop_control = U_WB | U_LB; alu_result = 16'h00C3;
        step();
        uop_control = '0;
        check("bypass_opb", operand_b, 16'h00C3);

        // Reset mid-operation discards load, latch and writeback
        reset = 1'b1; ir_load = 1'b1; instruction_in = 16'hFFFF;
        uop_control = U_WB | U_LA | U_LB; alu_result = 16'h5555;
        step();
        reset = 1'b0; ir_load = 1'b0; uop_control = '0;
        check("rst_mid_opa",   operand_a, 16'h0000);
        check("rst_mid_opb",   operand_b, 16'h0000);
        check("rst_mid_zero",  {15'd0, zero_flag}, 16'h0000);
        check("rst_mid_opc",   {8'd0, ir_opcode}, 16'h0000);
        check("rst_mid_reg0",  store_data, 16'h0000);

        // Registers cleared: reg3 (was BEEF) and reg1 (was 00C3)
        ir_load = 1'b1; instruction_in = 16'h00C0;
        step();
        check("rst_reg3", store_data, 16'h0000);
        instruction_in = 16'h0040;
        step();
        ir_load = 1'b0;
        check("rst_reg1", store_data, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
